arbitro_memoria: RTL and testbench

Single-clock arbiter and sequencer that shares one `memoria` instance (8-bit data, 12-bit address, synchronous registered read) between two requesters: port 0 (instruction fetch) and port 1 (data load/store). Each request is accepted with a one-cycle grant. The block drives the memory address, data and write enable for exactly one access cycle, then returns read data with a one-cycle valid pulse. It sits between the fetch/execute units and the memory; top level ties `memoria.write_clock` and `memoria.read_clock` to `clock`.

---
 rtl/arbitro_memoria_if.sv | 30 +++
 rtl/arbitro_memoria.sv | 112 +++++++++++
 tb/tb_arbitro_memoria.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_memoria_if.sv
// Requester-side bus of arbitro_memoria: two request ports plus the shared read-return path.
interface arbitro_memoria_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );
endinterface

// File: rtl/arbitro_memoria.sv
// Two-port arbiter/sequencer in front of one synchronous-read memoria instance.
// Define ARBITRO_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
//
// state   | meaning
// OCIOSO  | idle, arbitrate pending requests and latch the winner
// ACESSO  | memory address/data/EscMen driven for one cycle, grant high
// CAPTURA | memory output valid, captured into rdata with rvalid pulse
module arbitro_memoria #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    arbitro_memoria_if.slave      bus,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_EscMen,
    input  logic [DATA_WIDTH-1:0] mem_saida
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        CAPTURA = 2'd2
    } estado_t;

    estado_t state;
    logic    own;
    logic    win;

`ifdef ARBITRO_RR_EN
    logic last;

    // On contention the port not served last wins; otherwise whoever asks.
    always_comb begin
        win = bus.req1;
        if (bus.req0 && bus.req1) begin
            win = ~last;
        end
    end
`else
    always_comb begin
        win = ~bus.req0;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= OCIOSO;
            own            <= 1'b1;
            bus.gnt0       <= 1'b0;
            bus.gnt1       <= 1'b0;
            bus.rvalid0    <= 1'b0;
            bus.rvalid1    <= 1'b0;
            bus.rdata      <= '0;
            bus.busy       <= 1'b0;
            mem_data       <= '0;
            mem_write_addr <= '0;
            mem_read_addr  <= '0;
            mem_EscMen     <= 1'b0;
`ifdef ARBITRO_RR_EN
            last           <= 1'b1;
`endif
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            mem_EscMen  <= 1'b0;
            case (state)
                OCIOSO: begin
                    if (bus.req0 || bus.req1) begin
                        own            <= win;
                        mem_write_addr <= win ? bus.addr1 : bus.addr0;
                        mem_read_addr  <= win ? bus.addr1 : bus.addr0;
                        mem_data       <= win ? bus.wdata1 : bus.wdata0;
                        mem_EscMen     <= win ? bus.we1 : bus.we0;
                        bus.gnt0       <= ~win;
                        bus.gnt1       <= win;
                        bus.busy       <= 1'b1;
                        state          <= ACESSO;
`ifdef ARBITRO_RR_EN
                        last           <= win;
`endif
                    end
                end
                ACESSO: begin
                    // mem_EscMen still holds the latched we for this access.
                    if (mem_EscMen) begin
                        state    <= OCIOSO;
                        bus.busy <= 1'b0;
                    end else begin
                        state    <= CAPTURA;
                    end
                end
                CAPTURA: begin
                    bus.rdata   <= mem_saida;
                    bus.rvalid0 <= ~own;
                    bus.rvalid1 <= own;
                    bus.busy    <= 1'b0;
                    state       <= OCIOSO;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed self-checking bench for arbitro_memoria with a behavioural memoria model.
module tb_arbitro_memoria;
    localparam int DW = 8;
    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_saida;
    logic [AW-1:0] mem_write_addr;
    logic [AW-1:0] mem_read_addr;
    logic          mem_EscMen;
    logic [DW-1:0] mem_arr [0:4095];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    arbitro_memoria_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    arbitro_memoria #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .mem_data       (mem_data),
        .mem_write_addr (mem_write_addr),
        .mem_read_addr  (mem_read_addr),
        .mem_EscMen     (mem_EscMen),
        .mem_saida      (mem_saida)
    );

    // memoria: write on falling edge, registered read on rising edge
    always @(negedge clock) if (mem_EscMen) mem_arr[mem_write_addr] <= mem_data;
    always @(posedge clock) mem_saida <= mem_arr[mem_read_addr];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear_reqs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic drop(input bit port);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
    endtask

    task automatic run_access(input bit port, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, output logic [DW-1:0] rd, output bit ok);
        ok = 1'b0;
        rd = 'x;
        issue(port, we, a, d);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (port ? bus.gnt1 : bus.gnt0) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        drop(port);
        if (!ok || we) return;
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (port ? bus.rvalid1 : bus.rvalid0) begin
                ok = 1'b1;
                rd = bus.rdata;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        clear_reqs();
        tick();
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, mem_EscMen} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, mem_EscMen});
        end
        checks++;
        if ({bus.rdata, mem_data, mem_write_addr, mem_read_addr} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {bus.rdata, mem_data, mem_write_addr, mem_read_addr});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b want=000", {bus.gnt0, bus.gnt1, bus.busy});
        end
    endtask

    task automatic test_write_read;
        do_reset();
        issue(1'b1, 1'b1, 12'h0A5, 8'h3C);
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL wr_gnt got=%b want=01", {bus.gnt0, bus.gnt1});
        end
        checks++;
        if ({mem_EscMen, bus.busy, mem_write_addr, mem_read_addr, mem_data} !== {1'b1, 1'b1, 12'h0A5, 12'h0A5, 8'h3C}) begin
            failures++;
            $display("FAIL wr_mem got=%b %b %h %h %h want=1 1 0a5 0a5 3c", mem_EscMen, bus.busy, mem_write_addr, mem_read_addr, mem_data);
        end
        tick();
        drop(1'b1);
        checks++;
        if ({bus.gnt1, mem_EscMen, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL wr_done got=%b want=000", {bus.gnt1, mem_EscMen, bus.busy});
        end
        issue(1'b0, 1'b0, 12'h0A5, 8'h00);
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, mem_EscMen} !== 3'b100) begin
            failures++;
            $display("FAIL rd_gnt got=%b want=100", {bus.gnt0, bus.gnt1, mem_EscMen});
        end
        tick();
        drop(1'b0);
        checks++;
        if (bus.rvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL rd_early got=%b want=0", bus.rvalid0);
        end
        tick();
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.busy, bus.rdata} !== {3'b100, 8'h3C}) begin
            failures++;
            $display("FAIL rd_data got=%b%b%b %h want=100 3c", bus.rvalid0, bus.rvalid1, bus.busy, bus.rdata);
        end
        tick();
        checks++;
        if ({bus.rvalid0, bus.rdata} !== {1'b0, 8'h3C}) begin
            failures++;
            $display("FAIL rd_hold got=%b %h want=0 3c", bus.rvalid0, bus.rdata);
        end
    endtask

    task automatic test_contention;
        do_reset();
        issue(1'b0, 1'b0, 12'h000, 8'h00);
        issue(1'b1, 1'b0, 12'h001, 8'h00);
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            failures++;
            $display("FAIL cont_first got=%b want=10", {bus.gnt0, bus.gnt1});
        end
        tick();
        drop(1'b0);
        tick();
        checks++;
        if ({bus.rvalid0, bus.gnt0, bus.gnt1, bus.rdata} !== {3'b100, 8'h5A}) begin
            failures++;
            $display("FAIL cont_rd0 got=%b%b%b %h want=100 5a", bus.rvalid0, bus.gnt0, bus.gnt1, bus.rdata);
        end
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            failures++;
            $display("FAIL cont_second got=%b want=01", {bus.gnt0, bus.gnt1});
        end
        tick();
        drop(1'b1);
        tick();
        checks++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b10, 8'h5B}) begin
            failures++;
            $display("FAIL cont_rd1 got=%b%b %h want=10 5b", bus.rvalid1, bus.rvalid0, bus.rdata);
        end
    endtask

    task automatic test_back_to_back;
        int       ng;
        int       bad;
        bit       both;
        bit [6:0] seq;
        bit [6:0] want;
        ng = 0; bad = 0; both = 1'b0; seq = '0;
`ifdef ARBITRO_RR_EN
        want = 7'b0101010;
`else
        want = 7'b0000000;
`endif
        do_reset();
        issue(1'b0, 1'b0, 12'h000, 8'h00);
        issue(1'b1, 1'b0, 12'h001, 8'h00);
        for (int c = 0; c < 21; c++) begin
            tick();
            if (bus.gnt0 && bus.gnt1) both = 1'b1;
            if (bus.gnt0 || bus.gnt1) begin
                if (ng < 7) seq[ng] = bus.gnt1;
                ng++;
            end
            if (bus.rvalid0 && bus.rdata !== 8'h5A) bad++;
            if (bus.rvalid1 && bus.rdata !== 8'h5B) bad++;
        end
        clear_reqs();
        checks++;
        if (ng != 7) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=7", ng);
        end
        checks++;
        if (both !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dual_gnt got=%b want=0", both);
        end
        checks++;
        if (seq !== want) begin
            failures++;
            $display("FAIL b2b_order got=%b want=%b", seq, want);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_rdata got=%0d bad want=0", bad);
        end
        tick();
        tick();
    endtask

    task automatic test_top_address;
        do_reset();
        issue(1'b1, 1'b1, 12'hFFF, 8'hFF);
        tick();
        checks++;
        if ({mem_EscMen, mem_write_addr, mem_read_addr, mem_data} !== {1'b1, 12'hFFF, 12'hFFF, 8'hFF}) begin
            failures++;
            $display("FAIL top_wr got=%b %h %h %h want=1 fff fff ff", mem_EscMen, mem_write_addr, mem_read_addr, mem_data);
        end
        tick();
        drop(1'b1);
        issue(1'b0, 1'b0, 12'hFFF, 8'h00);
        tick();
        checks++;
        if ({bus.gnt0, mem_EscMen, mem_read_addr, mem_write_addr} !== {2'b10, 12'hFFF, 12'hFFF}) begin
            failures++;
            $display("FAIL top_rd_addr got=%b%b %h %h want=10 fff fff", bus.gnt0, mem_EscMen, mem_read_addr, mem_write_addr);
        end
        tick();
        drop(1'b0);
        tick();
        checks++;
        if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'hFF}) begin
            failures++;
            $display("FAIL top_rd_data got=%b %h want=1 ff", bus.rvalid0, bus.rdata);
        end
    endtask

    task automatic test_reset_captura;
        logic [DW-1:0] rd;
        bit            ok;
        bit            seen;
        do_reset();
        run_access(1'b0, 1'b0, 12'h0A5, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h3C) begin
            failures++;
            $display("FAIL rc_pre got=%b %h want=1 3c", ok, rd);
        end
        issue(1'b1, 1'b0, 12'hFFF, 8'h00);
        tick();
        tick();
        drop(1'b1);
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, mem_EscMen, bus.rdata, mem_data, mem_write_addr, mem_read_addr} !== 46'h0) begin
            failures++;
            $display("FAIL rc_outputs got=%b%b%b%b%b%b %h %h %h %h want=all 0", bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                     bus.busy, mem_EscMen, bus.rdata, mem_data, mem_write_addr, mem_read_addr);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.rvalid0 || bus.rvalid1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rc_no_rvalid got=%b want=0", seen);
        end
        run_access(1'b1, 1'b0, 12'h0A5, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h3C) begin
            failures++;
            $display("FAIL rc_after got=%b %h want=1 3c", ok, rd);
        end
    endtask

    task automatic test_reset_acesso;
        logic [DW-1:0] rd;
        bit            ok;
        do_reset();
        issue(1'b0, 1'b1, 12'h010, 8'h55);
        tick();
        checks++;
        if ({bus.gnt0, mem_EscMen, mem_write_addr, mem_data} !== {2'b11, 12'h010, 8'h55}) begin
            failures++;
            $display("FAIL ra_acesso got=%b%b %h %h want=11 010 55", bus.gnt0, mem_EscMen, mem_write_addr, mem_data);
        end
        reset = 1'b1;
        tick();
        drop(1'b0);
        checks++;
        if ({bus.gnt0, bus.gnt1, mem_EscMen, bus.busy, bus.rvalid0} !== 5'b0) begin
            failures++;
            $display("FAIL ra_reset got=%b want=00000", {bus.gnt0, bus.gnt1, mem_EscMen, bus.busy, bus.rvalid0});
        end
        reset = 1'b0;
        tick();
        run_access(1'b1, 1'b0, 12'h010, 8'h00, rd, ok);
        checks++;
        if (!ok || rd !== 8'h55) begin
            failures++;
            $display("FAIL ra_readback got=%b %h want=1 55", ok, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = i[7:0] ^ 8'h5A;
        clear_reqs();
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_top_address();
        test_reset_captura();
        test_reset_acesso();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
